// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the writeback-port arbiter and sibling port arbiters.
package wb_arb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  typedef struct packed {
    logic                valid;
    logic [AW_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

  // Round-robin pointer advance with wrap at n.
  function automatic logic [31:0] rr_next(input logic [31:0] idx, input logic [31:0] n);
    logic [31:0] nxt;
    nxt = idx + 32'd1;
    if (nxt >= n) begin
      return 32'd0;
    end else begin
      return nxt;
    end
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder; the first valid index at or after ptr wins.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from farthest to nearest so the candidate closest to ptr is written last.
  always_comb begin
    grant = {N{1'b0}};
    idx   = {IW{1'b0}};
    any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end else begin
        j = j;
      end
      if (valid[j]) begin
        grant    = {N{1'b0}};
        grant[j] = 1'b1;
        idx      = IW'(j);
        any      = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ writeback units.
// Optional macro WB_ARB_X0_FILTER_EN: grants to address 0 are consumed without writing.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*XLEN-1:0]     req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     we,
  output logic [AW-1:0]            waddr,
  output logic [XLEN-1:0]          wdata,
  output logic [$clog2(NREQ)-1:0]  grant_idx
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   r_ptr;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic [IW-1:0]   r_grant_idx;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_xfer;
  logic [AW-1:0]   w_addr;
  logic [XLEN-1:0] w_data;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .valid (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  // Reset and stall both gate the grant; the pick itself only ever selects valid requesters.
  assign w_xfer    = rst & ~hold & w_any;
  assign req_ready = w_xfer ? w_grant : {NREQ{1'b0}};
  assign w_addr    = req_addr[int'(w_idx)*AW +: AW];
  assign w_data    = req_data[int'(w_idx)*XLEN +: XLEN];

  // Write-port output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr       <= {IW{1'b0}};
      r_we        <= 1'b0;
      r_waddr     <= {AW{1'b0}};
      r_wdata     <= {XLEN{1'b0}};
      r_grant_idx <= {IW{1'b0}};
    end else if (w_xfer) begin
      r_ptr       <= IW'(rr_next(32'(w_idx), 32'(NREQ)));
      r_grant_idx <= w_idx;
`ifdef WB_ARB_X0_FILTER_EN
      if (w_addr == {AW{1'b0}}) begin
        r_we <= 1'b0;
      end else begin
        r_we    <= 1'b1;
        r_waddr <= w_addr;
        r_wdata <= w_data;
      end
`else
      r_we    <= 1'b1;
      r_waddr <= w_addr;
      r_wdata <= w_data;
`endif
    end else begin
      r_we <= 1'b0;
    end
  end

  assign we        = r_we;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign grant_idx = r_grant_idx;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (NREQ=3); honours WB_ARB_X0_FILTER_EN.
module tb_wb_port_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                 clk;
  logic                 rst;
  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 we;
  logic [AW-1:0]        waddr;
  logic [XLEN-1:0]      wdata;
  logic [1:0]           grant_idx;

  int n_chk;
  int n_err;

  wb_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    req_addr[i*AW +: AW]     = a;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b0;
    hold      = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    set_req(0, 5'd1, 32'h0000_000A);
    set_req(1, 5'd2, 32'h0000_000B);
    set_req(2, 5'd3, 32'h0000_000C);

    // Reset held 10 cycles with every requester valid.
    for (int c = 0; c < 10; c++) begin
      #1;
      check_eq("rst_ready", 64'(req_ready), 64'd0);
      tick();
      if (c == 0) begin
        check_eq("rst_we", 64'(we), 64'd0);
        check_eq("rst_waddr", 64'(waddr), 64'd0);
        check_eq("rst_wdata", 64'(wdata), 64'd0);
        check_eq("rst_gidx", 64'(grant_idx), 64'd0);
      end
    end

    // Round robin with all three valid.
    rst = 1'b1;
    begin
      logic [1:0]  exp_idx [4];
      logic [4:0]  exp_adr [4];
      logic [31:0] exp_dat [4];
      exp_idx = '{2'd0, 2'd1, 2'd2, 2'd0};
      exp_adr = '{5'd1, 5'd2, 5'd3, 5'd1};
      exp_dat = '{32'hA, 32'hB, 32'hC, 32'hA};
      for (int c = 0; c < 4; c++) begin
        #1;
        check_eq("rr_ready", 64'(req_ready), 64'(3'b001 << exp_idx[c]));
        tick();
        check_eq("rr_we", 64'(we), 64'd1);
        check_eq("rr_gidx", 64'(grant_idx), 64'(exp_idx[c]));
        check_eq("rr_waddr", 64'(waddr), 64'(exp_adr[c]));
        check_eq("rr_wdata", 64'(wdata), 64'(exp_dat[c]));
      end
    end

    // Single requester 2 granted back to back (ptr starts at 1).
    req_valid = 3'b100;
    set_req(2, 5'd7, 32'hDEAD_BEEF);
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("one_ready", 64'(req_ready), 64'(3'b100));
      tick();
      check_eq("one_we", 64'(we), 64'd1);
      check_eq("one_gidx", 64'(grant_idx), 64'd2);
      check_eq("one_waddr", 64'(waddr), 64'd7);
      check_eq("one_wdata", 64'(wdata), 64'hDEAD_BEEF);
    end

    // Hold with requesters 0 and 1 pending; ptr is 0.
    req_valid = 3'b011;
    hold      = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("hold_ready", 64'(req_ready), 64'd0);
      tick();
      check_eq("hold_we", 64'(we), 64'd0);
    end
    hold = 1'b0;
    #1;
    check_eq("unhold_ready", 64'(req_ready), 64'(3'b001));
    tick();
    check_eq("unhold_we", 64'(we), 64'd1);
    check_eq("unhold_gidx", 64'(grant_idx), 64'd0);
    #1;
    check_eq("unhold_ready2", 64'(req_ready), 64'(3'b010));
    tick();
    check_eq("unhold_gidx2", 64'(grant_idx), 64'd1);

    // ptr=2, only 0 and 1 valid: wrap to 0, then 1 would be granted when reset hits.
    #1;
    check_eq("wrap_ready", 64'(req_ready), 64'(3'b001));
    tick();
    check_eq("wrap_gidx", 64'(grant_idx), 64'd0);
    #1;
    check_eq("mid_ready_pre", 64'(req_ready), 64'(3'b010));
    rst = 1'b0;
    #1;
    check_eq("mid_ready_rst", 64'(req_ready), 64'd0);
    tick();
    check_eq("mid_we", 64'(we), 64'd0);
    check_eq("mid_gidx", 64'(grant_idx), 64'd0);
    check_eq("mid_waddr", 64'(waddr), 64'd0);
    rst = 1'b1;
    #1;
    check_eq("post_rst_ready", 64'(req_ready), 64'(3'b001));
    tick();
    check_eq("post_rst_we", 64'(we), 64'd1);
    check_eq("post_rst_gidx", 64'(grant_idx), 64'd0);
    check_eq("post_rst_waddr", 64'(waddr), 64'd1);

    // Address-0 write from requester 0; ptr=1 so the scan wraps to 0.
    req_valid = 3'b001;
    set_req(0, 5'd0, 32'h0000_0055);
    #1;
    check_eq("x0_ready", 64'(req_ready), 64'(3'b001));
    tick();
    check_eq("x0_gidx", 64'(grant_idx), 64'd0);
`ifdef WB_ARB_X0_FILTER_EN
    check_eq("x0_we", 64'(we), 64'd0);
    check_eq("x0_waddr_hold", 64'(waddr), 64'd1);
    check_eq("x0_wdata_hold", 64'(wdata), 64'hA);
`else
    check_eq("x0_we", 64'(we), 64'd1);
    check_eq("x0_waddr", 64'(waddr), 64'd0);
    check_eq("x0_wdata", 64'(wdata), 64'h55);
`endif
    // Pointer advanced to 1 either way.
    req_valid = 3'b011;
    #1;
    check_eq("x0_ptr", 64'(req_ready), 64'(3'b010));
    tick();
    check_eq("x0_next_gidx", 64'(grant_idx), 64'd1);
    check_eq("x0_next_waddr", 64'(waddr), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (an enabled D flip-flop bank) between NREQ writeback requesters, e.g. ALU, load unit and CSR unit.
- Grants one requester per cycle using round-robin priority.
- Captures the winning address and data in an output register stage.
- Drives the enable of the register bank; sits between the execute/memory units and the register file.

Parameters:
- NREQ, 3, number of requesters (2..8)
- XLEN, 32, write data width
- AW, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- hold  in  1  pipeline stall; blocks all grants while high
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  flattened destination addresses; requester i at [i*AW +: AW]
- req_data  in  NREQ*XLEN  flattened write data; requester i at [i*XLEN +: XLEN]
- req_ready  out  NREQ  one-hot (or zero) grant; combinational
- we  out  1  register-file write enable; registered
- waddr  out  AW  registered write address
- wdata  out  XLEN  registered write data
- grant_idx  out  $clog2(NREQ)  index of the requester driving the current we; registered

Behaviour:
- Interface: reset rst, synchronous, active-low; clock clk.
- Reset (rst=0 at posedge):
  - we=0, waddr=0, wdata=0, grant_idx=0, round-robin pointer ptr=0.
  - req_ready forced all-zero combinationally while rst=0.
- Grant (combinational):
  - If rst=1, hold=0 and any req_valid is set, req_ready asserts for exactly one i: the first valid index searching ptr, ptr+1, ... NREQ-1, 0, ... (wrap).
  - Otherwise req_ready=0.
  - req_ready never depends on itself and never asserts for a non-valid requester.
- Transfer:
  - Occurs when req_valid[i] && req_ready[i].
  - At that posedge: we<=1, waddr<=req_addr[i], wdata<=req_data[i], grant_idx<=i, ptr<=(i+1) mod NREQ.
  - Latency from transfer to we high is 1 cycle.
- No transfer:
  - we<=0; waddr, wdata and grant_idx hold their values; ptr holds.
- Requester rules:
  - Once asserted, valid/addr/data stay stable until the transfer.
  - The arbiter does not buffer losers; losers simply keep waiting.
- Fairness:
  - With all NREQ requesters continuously valid, each is granted exactly once per NREQ cycles.
  - No requester waits more than NREQ-1 cycles while hold=0.
- Boundaries:
  - Single valid requester: granted every cycle (back-to-back we=1).
  - hold=1 with valids pending: no grant; we=0 next cycle; ptr unchanged.
  - hold falling: grant in the same cycle hold is low.
  - rst=0 mid-operation: dominates hold and valids; a pending transfer is discarded; we=0 after that edge.
  - ptr wrap: after granting NREQ-1, ptr=0.

Optional Feature:
- Macro: WB_ARB_X0_FILTER_EN.
- Defined:
  - A transfer with req_addr[i]==0 still consumes the grant (ready, ptr advance, grant_idx update).
  - we<=0 for that cycle and waddr/wdata are not updated, so x0 is never written.
- Not defined: address 0 is written like any other address.

Decomposition:
- Package wb_arb_pkg:
  - XLEN and AW default constants.
  - wb_req_t struct {valid, addr, data}.
  - Function rr_next(idx, n) for pointer wrap.
- Sub-module rr_pick:
  - Combinational rotating-priority encoder.
  - Inputs: valid vector, ptr.
  - Outputs: one-hot grant, index, any.
  - Reused later by a memory-port arbiter.

Test Plan:
- Reset: hold rst=0 10 cycles with all valids=1 -> req_ready=0 throughout; we=0, waddr=0, wdata=0, grant_idx=0 after the first edge.
- Round-robin with all three valid, addrs 1/2/3, data 0xA/0xB/0xC -> we=1 every cycle; grant_idx sequence 0,1,2,0; waddr 1,2,3,1.
- Only requester 2 valid (addr 7, data 0xDEADBEEF) for 4 cycles -> we=1 for 4 consecutive cycles, grant_idx=2, waddr=7.
- hold=1 for 3 cycles with requesters 0 and 1 valid, then hold=0 -> req_ready=0 and we=0 during hold; first grant to ptr's requester in the cycle hold drops.
- Reset mid-stream: rst=0 in the cycle requester 1 is granted -> we=0 next cycle, ptr=0, first grant after release goes to requester 0.
- x0 write (macro defined): requester 0 addr 0 data 0x55 -> req_ready[0]=1, we stays 0, ptr advances to 1. Macro undefined -> we=1, waddr=0, wdata=0x55.
